enc_stream_ctrl: RTL and testbench
==================================

Name: enc_stream_ctrl

Overview:
- Stream front/back end for the 16-bit `encryption` core.
- Upstream side: accepts a 16-bit key and a byte stream over valid/ready, packs byte pairs into 16-bit plaintext words, and drives the core's `codein`/`key` inputs.
- Downstream side: tracks each word through the core's fixed latency, captures `codeout` into a small output FIFO, and presents ciphertext words over valid/ready.
- Credit-based issue, because the core cannot stall.

Parameters:
- LATENCY, 10: clock edges from a `core_codein` update to the edge at which the matching `core_codeout` is sampled (min 1).
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  key offered.
- key_ready  out  1  key accepted when key_valid & key_ready.
- key_in  in  16  key value.
- in_valid  in  1  plaintext byte offered.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- in_byte  in  8  plaintext byte; first byte of a pair = high byte.
- core_codein  out  16  registered plaintext word to the core.
- core_key  out  16  registered key to the core.
- core_codeout  in  16  ciphertext from the core.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes head word.
- out_data  out  16  FIFO head (first-word fall-through).
- busy  out  1  state==S_LO, or inflight≠0, or FIFO non-empty.

Behaviour:
Reset (async assert, sync release):
- State S_NOKEY; all registers cleared.
- core_codein = 0, core_key = 0.
- FIFO empty; inflight = 0; valid pipe cleared.
- out_valid = 0, out_data = 0, in_ready = 0, key_ready = 1, busy = 0.
- Reset mid-operation discards the partial byte, in-flight words and FIFO contents with no output.

FSM:
- S_NOKEY: in_ready = 0. Key accept → core_key <= key_in; go to S_HI.
- S_HI: awaiting high byte. Byte accept → hold in hi_reg; go to S_LO.
- S_LO: awaiting low byte. Byte accept → core_codein <= {hi_reg, in_byte}; set valid pipe stage 0; go to S_HI.

key_ready:
- = (state≠S_LO) & (inflight==0).
- A key may be reloaded in S_HI between words; core_key updates on the accept edge.

in_ready:
- = state∈{S_HI, S_LO} & !(key_valid & key_ready).
- Key accept has priority; no byte is accepted in the same cycle as a key.
- In S_LO only, additionally requires inflight + fifo_count < FIFO_DEPTH (credit check), so a captured word always has a FIFO slot.

Valid pipe and capture:
- Valid pipe is LATENCY bits.
- A bit set on issue edge E reaches the last stage so that, at edge E+LATENCY, core_codeout is pushed into the FIFO.
- inflight counts set bits in the pipe: +1 on issue, −1 on capture; both in the same cycle → unchanged.

FIFO:
- Circular buffer with wr/rd pointers wrapping modulo FIFO_DEPTH; fifo_count from 0 to FIFO_DEPTH.
- Pop when out_valid & out_ready.
- Push and pop in the same cycle: count unchanged; legal when full (pop frees the slot) and when empty is impossible (push happens after the empty check; out_valid reflects registered count).
- out_data = mem[rd_ptr] when non-empty; 0 when empty.
- Overflow cannot occur by construction. An assertion in the bench checks push with count==FIFO_DEPTH & no pop never happens.

Ordering:
- Output words leave in issue order.
- Each word is paired with the key that was in core_key on its issue edge; the reload rule (inflight==0) guarantees this.

Test Plan:
1. Reset, then key 16'h3A94 with key_valid for 1 cycle → key_ready=1, core_key=16'h3A94 next edge, state S_HI, in_ready=1, out_valid=0, busy=0.
2. Bytes 8'h12, 8'h34 on consecutive cycles → core_codein=16'h1234 after the second edge; exactly 10 edges later out_valid=1 and out_data equals the reference-model ciphertext of 16'h1234 under 16'h3A94.
3. out_ready=0, stream 10 bytes (5 words) with FIFO_DEPTH=4 → in_ready drops in S_LO after 4 words issued; 5th word not issued until out_ready pulses; no loss, order preserved.
4. Simultaneous push and pop with FIFO full: hold out_ready=1 with continuous input → fifo_count stays constant, pointers wrap past 3→0, all words match the model.
5. key_valid asserted while words are in flight → key_ready=0 until the last capture; then new key 16'hFFFF accepted; subsequent word 16'h0000 encrypted under 16'hFFFF, earlier words under the old key.
6. rst_n pulsed low asynchronously mid-stream (state S_LO, 2 in flight, FIFO 1 entry) → all outputs immediately at reset values; no stale word appears on out_valid after release.

Source files
------------

// File: rtl/enc_stream_ctrl.sv
// Stream front/back end for the 16-bit encryption core.
// Packs byte pairs into words, tracks core latency, buffers ciphertext.
module enc_stream_ctrl #(
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [15:0] key_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    output logic [15:0] core_codein,
    output logic [15:0] core_key,
    input  logic [15:0] core_codeout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(LATENCY + FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]         hi_reg;
    logic [LATENCY-1:0] vpipe;
    logic [IW-1:0]      inflight;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        fifo_count;

    logic key_fire;
    logic byte_fire;
    logic issue;
    logic push;
    logic pop;
    logic credit_ok;

    assign key_fire  = key_valid & key_ready;
    assign byte_fire = in_valid & in_ready;
    assign issue     = byte_fire & (state == S_LO);
    assign push      = vpipe[LATENCY-1];
    assign pop       = out_valid & out_ready;

    // Reserve a FIFO slot for every word still travelling through the core.
    assign credit_ok = (SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_NOKEY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_NOKEY: if (key_fire)  state_nx = S_HI;
            S_HI:    if (byte_fire) state_nx = S_LO;
            S_LO:    if (byte_fire) state_nx = S_HI;
            default: state_nx = S_NOKEY;
        endcase
    end

    always_comb begin
        key_ready = (state != S_LO) && (inflight == '0);
        in_ready  = 1'b0;
        unique case (state)
            S_NOKEY: in_ready = 1'b0;
            S_HI:    in_ready = !key_fire;
            S_LO:    in_ready = !key_fire && credit_ok;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_key    <= '0;
            core_codein <= '0;
            hi_reg      <= '0;
        end else begin
            if (key_fire) begin
                core_key <= key_in;
            end
            if (byte_fire && state == S_HI) begin
                hi_reg <= in_byte;
            end
            if (issue) begin
                core_codein <= {hi_reg, in_byte};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vpipe[i] <= vpipe[i-1];
            end
            vpipe[0] <= issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({issue, push})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= core_codeout;
            wr_ptr      <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign busy = (state == S_LO) || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_enc_stream_ctrl.sv
// Directed bench for enc_stream_ctrl with a behavioural core and
// a byte-level scoreboard of expected ciphertext.
module tb_enc_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [15:0] key_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = '0;
    logic [15:0] core_codein;
    logic [15:0] core_key;
    logic [15:0] core_codeout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int total = 0;
    int bad = 0;
    int pops = 0;

    logic [15:0] q [$];
    logic [15:0] model_key = '0;
    logic        hi_phase = 1'b0;
    logic [7:0]  hi_b = '0;
    logic [15:0] cs [9];

    enc_stream_ctrl #(.LATENCY(10), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_in(key_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_byte(in_byte),
        .core_codein(core_codein),
        .core_key(core_key),
        .core_codeout(core_codeout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [15:0] c, input logic [15:0] k);
        return {c[12:0], c[15:13]} ^ k;
    endfunction

    // Behavioural core: codeout sampled LATENCY edges after codein changes.
    always @(posedge clk) begin
        cs[0] <= enc(core_codein, core_key);
        for (int i = 1; i < 9; i++) begin
            cs[i] <= cs[i-1];
        end
    end
    assign core_codeout = cs[8];

    function automatic void chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endfunction

    function automatic void chk16(input string tag, input logic [15:0] obs,
                                  input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_phase = 1'b0;
        end else begin
            if (key_valid && key_ready) begin
                model_key = key_in;
            end
            if (in_valid && in_ready) begin
                if (!hi_phase) begin
                    hi_b = in_byte;
                end else begin
                    q.push_back(enc({hi_b, in_byte}, model_key));
                end
                hi_phase = !hi_phase;
            end
            if (out_valid && out_ready) begin
                pops++;
                chk1("pop_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    chk16("pop_data", out_data, q.pop_front());
                end
            end
            assert (!(dut.push && dut.fifo_count == 3'd4 && !dut.pop)) else begin
                bad++;
                $error("FAIL fifo_overflow observed=push_on_full expected=none");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk1("send_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        #1;
        while ((out_valid || q.size() != 0) && n < 80) begin
            tick();
            n++;
        end
        chk1("drain_valid", out_valid, 1'b0);
        chk16("drain_q", 16'(q.size()), 16'd0);
        out_ready = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk16({tag, "_out_data"}, out_data, 16'h0000);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_key_ready"}, key_ready, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk16({tag, "_codein"}, core_codein, 16'h0000);
        chk16({tag, "_core_key"}, core_key, 16'h0000);
    endtask

    initial begin
        int p0;
        logic saw;

        // Reset values
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Key load
        key_in    = 16'h3A94;
        key_valid = 1'b1;
        #1;
        chk1("k_ready", key_ready, 1'b1);
        chk1("k_nokey_in_ready", in_ready, 1'b0);
        tick();
        key_valid = 1'b0;
        #1;
        chk16("k_core_key", core_key, 16'h3A94);
        chk1("k_in_ready", in_ready, 1'b1);
        chk1("k_out_valid", out_valid, 1'b0);
        chk1("k_busy", busy, 1'b0);

        // First word and exact latency
        send_byte(8'h12);
        chk1("w1_busy_lo", busy, 1'b1);
        send_byte(8'h34);
        chk16("w1_codein", core_codein, 16'h1234);
        repeat (9) tick();
        chk1("w1_not_yet", out_valid, 1'b0);
        tick();
        chk1("w1_valid", out_valid, 1'b1);
        chk16("w1_data", out_data, 16'hAB34);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk1("w1_popped", out_valid, 1'b0);

        // Credit stall with the consumer blocked
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
        end
        in_byte  = 8'h0A;
        in_valid = 1'b1;
        #1;
        chk1("cr_stall", in_ready, 1'b0);
        repeat (12) tick();
        chk1("cr_stall_hold", in_ready, 1'b0);
        chk1("cr_out_valid", out_valid, 1'b1);
        chk1("cr_key_ready", key_ready, 1'b0);
        chk16("cr_head", out_data, enc(16'h0102, 16'h3A94));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk1("cr_release", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        drain();

        // Continuous stream with the consumer always ready
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h40 + 8'(i));
        end
        drain();
        chk16("str_pops", 16'(pops - p0), 16'd8);

        // Key reload blocked while a word is in flight
        send_byte(8'hAB);
        send_byte(8'hCD);
        key_in    = 16'hFFFF;
        key_valid = 1'b1;
        #1;
        chk1("rk_blocked", key_ready, 1'b0);
        repeat (9) tick();
        chk1("rk_still_blocked", key_ready, 1'b0);
        tick();
        chk1("rk_open", key_ready, 1'b1);
        chk16("rk_old_word", out_data, 16'h64F9);
        tick();
        key_valid = 1'b0;
        #1;
        chk16("rk_core_key", core_key, 16'hFFFF);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (10) tick();
        chk16("rk_head_old", out_data, 16'h64F9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk16("rk_new_word", out_data, 16'hFFFF);
        drain();

        // Asynchronous reset mid-stream
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (10) tick();
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        chk1("mr_busy", busy, 1'b1);
        chk1("mr_key_ready", key_ready, 1'b0);
        chk1("mr_out_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mr");
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            tick();
            saw = saw | out_valid;
        end
        chk1("mr_no_stale", saw, 1'b0);
        chk1("mr_busy_idle", busy, 1'b0);
        chk1("mr_nokey", in_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
